// File: rtl/pci_tl_pkg.sv
// Shared definitions for the transmit-logic drain path.
//   DEST_D0 / DEST_D1  : destination tags carried on dest_out and used as grant index
//   drain_state_t      : state encoding of the drain FSM (exposed on state_dbg)
//   DEFAULT_*_WIDTH    : default word / counter widths
package pci_tl_pkg;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 6;
  localparam int DEFAULT_CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } drain_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter with a registered pointer.
//   clk, reset : clock, asynchronous active-low reset (pointer -> D0)
//   req[1:0]   : req[0] = D0 has data, req[1] = D1 has data
//   advance    : a grant is being consumed this cycle; pointer moves past it
//   gnt        : granted side (DEST_D0 / DEST_D1); meaningful when |req
module rr_arbiter_2
  import pci_tl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt
);

  logic ptr_q;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    gnt = ptr_q;
    case (req)
      2'b01:   gnt = DEST_D0;
      2'b10:   gnt = DEST_D1;
      default: gnt = ptr_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= DEST_D0;
    end else if (advance) begin
      ptr_q <= ~gnt;
    end
  end

endmodule

// File: rtl/dest_drain_arbiter.sv
// Drains the D0/D1 destination FIFOs onto one tagged valid/ready stream.
// Optional feature macro: DRAIN_COUNT_EN (per-destination delivery counters).
//   clk, reset            : clock, asynchronous active-low reset
//   active_in             : new pops allowed
//   empty_D0/1            : FIFO empty flags
//   data_in_D0/1          : FIFO registered read data (valid the cycle after a pop)
//   D0_pop/D1_pop         : pop strobes (at most one high)
//   data_out/dest_out     : delivered word and its source tag
//   valid_out/ready_in    : output handshake
//   state_dbg             : current FSM state
//   count_D0/1, count_clear : delivery counters and synchronous clear (DRAIN_COUNT_EN)
//
// Handshake: a word transfers on every rising edge where valid_out && ready_in.
// While valid_out is high and ready_in is low, data_out/dest_out hold stable and
// valid_out stays high. valid_out never depends combinationally on ready_in.
module dest_drain_arbiter
  import pci_tl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef DRAIN_COUNT_EN
  ,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic                  empty_D0,
  input  logic                  empty_D1,
  input  logic [DATA_WIDTH-1:0] data_in_D0,
  input  logic [DATA_WIDTH-1:0] data_in_D1,
  output logic                  D0_pop,
  output logic                  D1_pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  dest_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output drain_state_t          state_dbg
`ifdef DRAIN_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  count_D0,
  output logic [CNT_WIDTH-1:0]  count_D1,
  input  logic                  count_clear
`endif
);

  drain_state_t state_q, state_d;
  logic         grant_q;
  logic         gnt;
  logic [1:0]   req;
  logic         can_pop;

  assign req = {~empty_D1, ~empty_D0};

  // Reset is folded in so pops are held low while reset is asserted even
  // though they are combinational from the FIFO flags.
  assign can_pop = reset && active_in && (|req) &&
                   ((state_q == ST_IDLE) || ((state_q == ST_SEND) && ready_in));

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (can_pop),
    .gnt     (gnt)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (can_pop) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_SEND;
      ST_SEND: begin
        if (ready_in) state_d = can_pop ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: pop strobes
  always_comb begin
    D0_pop = can_pop && (gnt == DEST_D0);
    D1_pop = can_pop && (gnt == DEST_D1);
  end

  assign state_dbg = state_q;

  // Output register. The FIFO read data is only valid in WAIT, so the word is
  // captured there; in SEND everything holds until the handshake completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q   <= DEST_D0;
      data_out  <= '0;
      dest_out  <= DEST_D0;
      valid_out <= 1'b0;
    end else begin
      if (can_pop) grant_q <= gnt;
      case (state_q)
        ST_WAIT: begin
          data_out  <= (grant_q == DEST_D1) ? data_in_D1 : data_in_D0;
          dest_out  <= grant_q;
          valid_out <= 1'b1;
        end
        ST_SEND: begin
          if (ready_in) valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DRAIN_COUNT_EN
  logic accept;
  assign accept = valid_out && ready_in;

  // Saturating delivery counters; clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_D0 <= '0;
      count_D1 <= '0;
    end else if (count_clear) begin
      count_D0 <= '0;
      count_D1 <= '0;
    end else begin
      if (accept && (dest_out == DEST_D0) && (count_D0 != '1))
        count_D0 <= count_D0 + CNT_WIDTH'(1);
      if (accept && (dest_out == DEST_D1) && (count_D1 != '1))
        count_D1 <= count_D1 + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Self-checking bench for dest_drain_arbiter: a per-cycle vector table for
// reset, single-word latency and grant rules, then FIFO-modelled sequences for
// round-robin streaming, back-pressure, active_in drop, mid-flight reset and
// (with DRAIN_COUNT_EN) the delivery counters.
module tb_dest_drain_arbiter;
  import pci_tl_pkg::*;

  localparam int DW = 6;
  localparam int CW = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          active_in, empty_D0, empty_D1, ready_in;
  logic [DW-1:0] data_in_D0, data_in_D1, data_out;
  logic          D0_pop, D1_pop, dest_out, valid_out;
  drain_state_t  state_dbg;
`ifdef DRAIN_COUNT_EN
  logic [CW-1:0] count_D0, count_D1;
  logic          count_clear;
`endif

  dest_drain_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .active_in  (active_in),
    .empty_D0   (empty_D0),
    .empty_D1   (empty_D1),
    .data_in_D0 (data_in_D0),
    .data_in_D1 (data_in_D1),
    .D0_pop     (D0_pop),
    .D1_pop     (D1_pop),
    .data_out   (data_out),
    .dest_out   (dest_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .state_dbg  (state_dbg)
`ifdef DRAIN_COUNT_EN
    ,
    .count_D0   (count_D0),
    .count_D1   (count_D1),
    .count_clear(count_clear)
`endif
  );

  // ---------------- scoreboard state ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW:0]   exp_q[$];          // {dest, data}
  logic [DW-1:0] q0[$], q1[$];      // FIFO contents model
  int            cyc_no   = 0;
  int            last_acc = -1;
  bit            spacing_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  task automatic upd_empty();
    empty_D0 = (q0.size() == 0);
    empty_D1 = (q1.size() == 0);
  endtask

  // Advance one clock with the FIFO model; returns at posedge+1.
  task automatic cyc();
    logic p0, p1;
    p0 = D0_pop;
    p1 = D1_pop;
    @(posedge clk);
    cyc_no++;
    #1;
    if (p0 && q0.size() > 0) data_in_D0 = q0.pop_front();
    if (p1 && q1.size() > 0) data_in_D1 = q1.pop_front();
    upd_empty();
  endtask

  task automatic check_point();
    logic [DW:0] e;
    if (valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_word: got %0h expected none", {dest_out, data_out});
      end else begin
        e = exp_q.pop_front();
        chk("word", {dest_out, data_out}, e);
        if (spacing_on && last_acc >= 0) chk("spacing", cyc_no - last_acc, 2);
        last_acc = cyc_no;
      end
    end
  endtask

  task automatic step();
    cyc();
    #3;
    check_point();
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    upd_empty();
    #3;
    cyc();
    reset = 1'b1;
    #3;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst_n, act, e0, e1;
    logic [DW-1:0] d0, d1;
    logic          rdy;
    logic          p0, p1, vld;
    drain_state_t  st;
    logic [DW-1:0] dout;
    logic          dst;
    logic          chk_data;
  } vec_t;

  function automatic vec_t v(logic rst_n, logic act, logic e0, logic e1,
                             logic [DW-1:0] d0, logic [DW-1:0] d1, logic rdy,
                             logic p0, logic p1, logic vld, drain_state_t st,
                             logic [DW-1:0] dout, logic dst, logic chk_data);
    vec_t r;
    r.rst_n = rst_n; r.act = act; r.e0 = e0; r.e1 = e1; r.d0 = d0; r.d1 = d1;
    r.rdy = rdy; r.p0 = p0; r.p1 = p1; r.vld = vld; r.st = st;
    r.dout = dout; r.dst = dst; r.chk_data = chk_data;
    return r;
  endfunction

  vec_t vecs[19];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [DW-1:0] w;
    logic [31:0]   act_v, exp_v;
    reset = 1'b0; active_in = 1'b1; ready_in = 1'b1;
    empty_D0 = 1'b1; empty_D1 = 1'b1; data_in_D0 = '0; data_in_D1 = '0;
`ifdef DRAIN_COUNT_EN
    count_clear = 1'b0;
`endif
    //             rst act e0 e1 d0     d1     rdy | p0 p1 vld state    dout   dst chk
    vecs[0]  = v(0, 1, 1, 1, 6'h00, 6'h00, 1,  0, 0, 0, ST_IDLE, 6'h00, 0, 1);
    vecs[1]  = v(0, 1, 0, 0, 6'h00, 6'h00, 1,  0, 0, 0, ST_IDLE, 6'h00, 0, 1);
    vecs[2]  = v(1, 1, 1, 1, 6'h00, 6'h00, 1,  0, 0, 0, ST_IDLE, 6'h00, 0, 1);
    vecs[3]  = v(1, 1, 1, 1, 6'h00, 6'h00, 1,  0, 0, 0, ST_IDLE, 6'h00, 0, 1);
    vecs[4]  = v(1, 1, 0, 1, 6'h00, 6'h00, 1,  1, 0, 0, ST_IDLE, 6'h00, 0, 1);
    vecs[5]  = v(1, 1, 1, 1, 6'h05, 6'h00, 1,  0, 0, 0, ST_WAIT, 6'h00, 0, 1);
    vecs[6]  = v(1, 1, 1, 1, 6'h05, 6'h00, 1,  0, 0, 1, ST_SEND, 6'h05, 0, 1);
    vecs[7]  = v(1, 1, 0, 0, 6'h05, 6'h00, 1,  0, 1, 0, ST_IDLE, 6'h00, 0, 0);
    vecs[8]  = v(1, 1, 0, 0, 6'h05, 6'h22, 1,  0, 0, 0, ST_WAIT, 6'h00, 0, 0);
    vecs[9]  = v(1, 1, 0, 0, 6'h05, 6'h22, 0,  0, 0, 1, ST_SEND, 6'h22, 1, 1);
    vecs[10] = v(1, 1, 0, 0, 6'h05, 6'h22, 1,  1, 0, 1, ST_SEND, 6'h22, 1, 1);
    vecs[11] = v(1, 1, 1, 0, 6'h04, 6'h22, 1,  0, 0, 0, ST_WAIT, 6'h00, 0, 0);
    vecs[12] = v(1, 1, 1, 0, 6'h04, 6'h22, 1,  0, 1, 1, ST_SEND, 6'h04, 0, 1);
    vecs[13] = v(1, 0, 1, 0, 6'h04, 6'h23, 1,  0, 0, 0, ST_WAIT, 6'h00, 0, 0);
    vecs[14] = v(1, 0, 0, 0, 6'h04, 6'h23, 1,  0, 0, 1, ST_SEND, 6'h23, 1, 1);
    vecs[15] = v(1, 0, 0, 0, 6'h04, 6'h23, 1,  0, 0, 0, ST_IDLE, 6'h00, 0, 0);
    vecs[16] = v(1, 1, 1, 0, 6'h04, 6'h23, 1,  0, 1, 0, ST_IDLE, 6'h00, 0, 0);
    vecs[17] = v(1, 1, 1, 1, 6'h04, 6'h21, 1,  0, 0, 0, ST_WAIT, 6'h00, 0, 0);
    vecs[18] = v(1, 1, 1, 1, 6'h04, 6'h21, 1,  0, 0, 1, ST_SEND, 6'h21, 1, 1);

    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      cyc_no++;
      #1;
      reset = vecs[i].rst_n; active_in = vecs[i].act;
      empty_D0 = vecs[i].e0; empty_D1 = vecs[i].e1;
      data_in_D0 = vecs[i].d0; data_in_D1 = vecs[i].d1; ready_in = vecs[i].rdy;
      #3;
      act_v = {D0_pop, D1_pop, valid_out, state_dbg,
               (vecs[i].chk_data ? data_out : 6'h00),
               (vecs[i].chk_data ? dest_out : 1'b0)};
      exp_v = {vecs[i].p0, vecs[i].p1, vecs[i].vld, vecs[i].st,
               vecs[i].dout, vecs[i].dst};
      chk($sformatf("vec%0d", i), act_v, exp_v);
    end

    // ---- round-robin stream, one word every 2 cycles ----
    do_reset();
    q0 = '{6'h05, 6'h04, 6'h06};
    q1 = '{6'h22, 6'h23, 6'h21};
    exp_q = '{7'h05, 7'h62, 7'h04, 7'h63, 7'h06, 7'h61};
    active_in = 1'b1; ready_in = 1'b1;
    upd_empty();
    #1;
    spacing_on = 1; last_acc = -1;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) step();
    chk("rr_drained", exp_q.size(), 0);
    spacing_on = 0;

    // ---- back-pressure: hold 6'b000110 for 5 cycles ----
    do_reset();
    q0 = '{6'h06};
    q1 = '{6'h21};
    exp_q = '{7'h06, 7'h61};
    ready_in = 1'b0;
    upd_empty();
    #1;
    for (int k = 0; k < 10 && !valid_out; k++) step();
    chk("stall_valid", valid_out, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_hold", {valid_out, dest_out, data_out}, {1'b1, 1'b0, 6'h06});
      chk("stall_nopop", {D0_pop, D1_pop}, 2'b00);
    end
    cyc();
    ready_in = 1'b1;
    #3;
    chk("resume_pop", {D0_pop, D1_pop}, 2'b01);
    check_point();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) step();
    chk("stall_drained", exp_q.size(), 0);

    // ---- active_in drops the cycle after a D1 pop ----
    do_reset();
    q0 = '{6'h01, 6'h02};
    q1 = '{6'h11, 6'h12};
    exp_q = '{7'h01, 7'h51};
    upd_empty();
    #1;
    for (int k = 0; k < 10 && !D1_pop; k++) step();
    chk("d1_pop_seen", D1_pop, 1);
    cyc();
    active_in = 1'b0;
    #3;
    check_point();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("inactive_nopop", {D0_pop, D1_pop}, 2'b00);
    end
    chk("inactive_drained", exp_q.size(), 0);
    cyc();
    active_in = 1'b1;
    #3;
    chk("resume_d0", {D0_pop, D1_pop}, 2'b10);

    // ---- reset during WAIT; pointer returns to D0 ----
    cyc();
    chk("in_wait", state_dbg, ST_WAIT);
    reset = 1'b0;
    #2;
    chk("reset_mid", {valid_out, D0_pop, D1_pop, state_dbg, dest_out, data_out},
        {1'b0, 1'b0, 1'b0, ST_IDLE, 1'b0, 6'h00});
    exp_q.delete();
    cyc();
    reset = 1'b1;
    q0.push_back(6'h03);
    upd_empty();
    #3;
    chk("ptr_reset", {D0_pop, D1_pop}, 2'b10);

`ifdef DRAIN_COUNT_EN
    // ---- delivery counters ----
    do_reset();
    chk("cnt_reset", {count_D0, count_D1}, 10'h000);
    q0 = '{6'h0a, 6'h0b, 6'h0c};
    q1 = '{6'h2a, 6'h2b};
    exp_q = '{7'h0a, 7'h6a, 7'h0b, 7'h6b, 7'h0c};
    upd_empty();
    #1;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) step();
    step();
    chk("cnt_3_2", {count_D0, count_D1}, {5'd3, 5'd2});
    for (int k = 0; k < 40; k++) begin
      w = 6'($urandom_range(0, 63));
      q0.push_back(w);
      exp_q.push_back({1'b0, w});
    end
    upd_empty();
    #1;
    for (int k = 0; k < 120 && exp_q.size() > 0; k++) step();
    step();
    chk("cnt_sat", {count_D0, count_D1}, {5'd31, 5'd2});
    count_clear = 1'b1;
    #1;
    cyc();
    count_clear = 1'b0;
    #3;
    chk("cnt_clear", {count_D0, count_D1}, 10'h000);
    q0.push_back(6'h15);
    exp_q.push_back(7'h15);
    upd_empty();
    #1;
    for (int k = 0; k < 10 && !(valid_out && ready_in); k++) step();
    count_clear = 1'b1;
    #1;
    cyc();
    count_clear = 1'b0;
    #3;
    chk("cnt_clear_wins", count_D0, 5'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
